// File: rtl/lht_update_queue.sv
// lht_update_queue
// Small coalescing FIFO between the two branch-resolve ports and the single
// LHT update port. Entries are keyed by {PC[31:1], ASID}. A repeat update to
// a queued key overwrites that entry's local history in place. The head
// drains one entry per cycle. A drain is held off while the head collides
// with a same-set fetch read, for at most STALL_MAX consecutive cycles.
module lht_update_queue #(
    parameter int DEPTH      = 4,
    parameter int STALL_MAX  = 3,
    parameter int ASID_WIDTH = 9,
    parameter int LH_LENGTH  = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          resolve0_valid,
    input  logic [31:0]                   resolve0_start_full_PC,
    input  logic [ASID_WIDTH-1:0]         resolve0_ASID,
    input  logic [LH_LENGTH-1:0]          resolve0_LH,
    input  logic                          resolve1_valid,
    input  logic [31:0]                   resolve1_start_full_PC,
    input  logic [ASID_WIDTH-1:0]         resolve1_ASID,
    input  logic [LH_LENGTH-1:0]          resolve1_LH,
    output logic                          resolve_ready,
    input  logic                          valid_REQ,
    input  logic [31:0]                   full_PC_REQ,
    output logic                          update0_valid,
    output logic [31:0]                   update0_start_full_PC,
    output logic [ASID_WIDTH-1:0]         update0_ASID,
    output logic [LH_LENGTH-1:0]          update0_LH,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy,
    output logic                          overflow_error
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
    localparam int KW = 31 + ASID_WIDTH;

    // Queue storage and control state
    logic [DEPTH-1:0]       valid_reg;
    logic [31:0]            pc_reg   [DEPTH];
    logic [ASID_WIDTH-1:0]  asid_reg [DEPTH];
    logic [LH_LENGTH-1:0]   lh_reg   [DEPTH];
    logic [PW-1:0]          head_reg;
    logic [PW-1:0]          tail_reg;
    logic [CW-1:0]          count_reg;
    logic [SW-1:0]          stall_reg;
    logic                   overflow_reg;

    // Drain-side signals
    logic                   empty;
    logic                   conflict;
    logic                   stall_full;
    logic                   drain;

    // Enqueue-side signals
    logic [KW-1:0]          key0;
    logic [KW-1:0]          key1;
    logic                   keys_equal;
    logic [DEPTH-1:0]       live;
    logic [DEPTH-1:0]       hit0;
    logic [DEPTH-1:0]       hit1;
    logic                   r0_take;
    logic                   r0_hit;
    logic [PW-1:0]          r0_idx;
    logic                   r0_alloc;
    logic                   r0_drop;
    logic                   r1_hit;
    logic [PW-1:0]          r1_idx;
    logic                   r1_alloc;
    logic                   r1_drop;
    logic [CW:0]            free0;
    logic [CW:0]            free1;
    logic [PW-1:0]          tail1;
    logic [CW-1:0]          count_next;
    logic [PW-1:0]          tail_next;

    // Only the set-index bits of the fetch PC take part in the conflict check
    logic                   unused_req_bits;
    assign unused_req_bits = ^{full_PC_REQ[31:9], full_PC_REQ[3:0]};

    assign empty      = (count_reg == '0);
    assign conflict   = valid_REQ & (full_PC_REQ[8:4] == pc_reg[head_reg][8:4]);
    assign stall_full = (stall_reg == SW'(STALL_MAX));
    assign drain      = ~empty & (~conflict | stall_full);

    assign update0_valid         = drain;
    assign update0_start_full_PC = empty ? '0 : pc_reg[head_reg];
    assign update0_ASID          = empty ? '0 : asid_reg[head_reg];
    assign update0_LH            = empty ? '0 : lh_reg[head_reg];
    assign occupancy             = count_reg;
    assign overflow_error        = overflow_reg;
    assign resolve_ready         = (({1'b0, count_reg} + (CW+1)'(2)) <= (CW+1)'(DEPTH));

    assign key0       = {resolve0_start_full_PC[31:1], resolve0_ASID};
    assign key1       = {resolve1_start_full_PC[31:1], resolve1_ASID};
    assign keys_equal = (key0 == key1);

    // Per-slot key match; the head leaving this cycle is no longer a coalesce target
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign live[gi] = valid_reg[gi] & ~(drain & (head_reg == PW'(gi)));
            assign hit0[gi] = live[gi] & ({pc_reg[gi][31:1], asid_reg[gi]} == key0);
            assign hit1[gi] = live[gi] & ({pc_reg[gi][31:1], asid_reg[gi]} == key1);
        end
    endgenerate

    // Enqueue decision: resolve0 first, then resolve1 against the updated picture
    always_comb begin
        r0_idx = '0;
        r1_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit0[i]) r0_idx = PW'(i);
            if (hit1[i]) r1_idx = PW'(i);
        end

        // An older update superseded by the younger one in the same cycle is discarded
        r0_take  = resolve0_valid & ~(resolve1_valid & keys_equal);
        r0_hit   = r0_take & (|hit0);
        free0    = (CW+1)'(DEPTH) - {1'b0, count_reg} + {{CW{1'b0}}, drain};
        r0_alloc = r0_take & ~r0_hit & (free0 != '0);
        r0_drop  = r0_take & ~r0_hit & (free0 == '0);

        tail1    = tail_reg + PW'(r0_alloc);
        free1    = free0 - {{CW{1'b0}}, r0_alloc};

        r1_hit   = resolve1_valid & ((|hit1) | (r0_alloc & keys_equal));
        if (resolve1_valid & ~(|hit1) & r0_alloc & keys_equal) begin
            r1_idx = tail_reg;
        end
        r1_alloc = resolve1_valid & ~r1_hit & (free1 != '0);
        r1_drop  = resolve1_valid & ~r1_hit & (free1 == '0);

        tail_next  = tail_reg + PW'(r0_alloc) + PW'(r1_alloc);
        count_next = count_reg + CW'(r0_alloc) + CW'(r1_alloc) - CW'(drain);
    end

    // Queue state update: pop head, then apply resolve0 and resolve1 writes in order
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_reg    <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_reg[i]   <= '0;
                asid_reg[i] <= '0;
                lh_reg[i]   <= '0;
            end
        end else begin
            if (drain) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PW'(1);
            end
            if (r0_hit) begin
                lh_reg[r0_idx] <= resolve0_LH;
            end
            if (r0_alloc) begin
                valid_reg[tail_reg] <= 1'b1;
                pc_reg[tail_reg]    <= resolve0_start_full_PC;
                asid_reg[tail_reg]  <= resolve0_ASID;
                lh_reg[tail_reg]    <= resolve0_LH;
            end
            if (r1_hit) begin
                lh_reg[r1_idx] <= resolve1_LH;
            end
            if (r1_alloc) begin
                valid_reg[tail1] <= 1'b1;
                pc_reg[tail1]    <= resolve1_start_full_PC;
                asid_reg[tail1]  <= resolve1_ASID;
                lh_reg[tail1]    <= resolve1_LH;
            end
            if (r0_drop | r1_drop) begin
                overflow_reg <= 1'b1;
            end
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Conflict stall counter: counts blocked cycles of a nonempty queue, saturating
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_reg <= '0;
        end else if (empty | drain) begin
            stall_reg <= '0;
        end else if (conflict & ~stall_full) begin
            stall_reg <= stall_reg + SW'(1);
        end
    end

endmodule

// File: tb/tb_lht_update_queue.sv
// Directed bench for lht_update_queue: one line per checked transaction.
module tb_lht_update_queue;

    logic        CLK;
    logic        RST;
    logic        resolve0_valid;
    logic [31:0] resolve0_start_full_PC;
    logic [8:0]  resolve0_ASID;
    logic [7:0]  resolve0_LH;
    logic        resolve1_valid;
    logic [31:0] resolve1_start_full_PC;
    logic [8:0]  resolve1_ASID;
    logic [7:0]  resolve1_LH;
    logic        resolve_ready;
    logic        valid_REQ;
    logic [31:0] full_PC_REQ;
    logic        update0_valid;
    logic [31:0] update0_start_full_PC;
    logic [8:0]  update0_ASID;
    logic [7:0]  update0_LH;
    logic [2:0]  occupancy;
    logic        overflow_error;

    int vectors;
    int miscompares;

    lht_update_queue #(.DEPTH(4), .STALL_MAX(3), .ASID_WIDTH(9), .LH_LENGTH(8)) dut (
        .CLK                    (CLK),
        .RST                    (RST),
        .resolve0_valid         (resolve0_valid),
        .resolve0_start_full_PC (resolve0_start_full_PC),
        .resolve0_ASID          (resolve0_ASID),
        .resolve0_LH            (resolve0_LH),
        .resolve1_valid         (resolve1_valid),
        .resolve1_start_full_PC (resolve1_start_full_PC),
        .resolve1_ASID          (resolve1_ASID),
        .resolve1_LH            (resolve1_LH),
        .resolve_ready          (resolve_ready),
        .valid_REQ              (valid_REQ),
        .full_PC_REQ            (full_PC_REQ),
        .update0_valid          (update0_valid),
        .update0_start_full_PC  (update0_start_full_PC),
        .update0_ASID           (update0_ASID),
        .update0_LH             (update0_LH),
        .occupancy              (occupancy),
        .overflow_error         (overflow_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) begin
            $display("[%0t] %s observed=%0h expected=%0h ok", $time, tag, obs, exp);
        end else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic r0(input logic [31:0] pc, input logic [8:0] asid, input logic [7:0] lh);
        resolve0_valid = 1'b1; resolve0_start_full_PC = pc; resolve0_ASID = asid; resolve0_LH = lh;
    endtask

    task automatic r1(input logic [31:0] pc, input logic [8:0] asid, input logic [7:0] lh);
        resolve1_valid = 1'b1; resolve1_start_full_PC = pc; resolve1_ASID = asid; resolve1_LH = lh;
    endtask

    task automatic rclr();
        resolve0_valid = 1'b0; resolve0_start_full_PC = '0; resolve0_ASID = '0; resolve0_LH = '0;
        resolve1_valid = 1'b0; resolve1_start_full_PC = '0; resolve1_ASID = '0; resolve1_LH = '0;
    endtask

    task automatic req(input logic v, input logic [31:0] pc);
        valid_REQ = v; full_PC_REQ = pc;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        RST = 1'b1;
        rclr();
        req(1'b0, 32'h0);
        #12;
        chk("reset_occ", 32'(occupancy), 32'd0);
        chk("reset_valid", 32'(update0_valid), 32'd0);
        chk("reset_ready", 32'(resolve_ready), 32'd1);
        chk("reset_ovf", 32'(overflow_error), 32'd0);
        chk("reset_pc", update0_start_full_PC, 32'h0);
        tick();
        RST = 1'b0;

        // Single update: visible the cycle after enqueue, then drained
        r0(32'h10, 9'd0, 8'hA5);
        settle();
        chk("single_nobypass", 32'(update0_valid), 32'd0);
        tick(); rclr(); settle();
        chk("single_valid", 32'(update0_valid), 32'd1);
        chk("single_pc", update0_start_full_PC, 32'h10);
        chk("single_lh", 32'(update0_LH), 32'hA5);
        chk("single_occ", 32'(occupancy), 32'd1);
        tick(); settle();
        chk("single_empty_occ", 32'(occupancy), 32'd0);
        chk("single_empty_pc", update0_start_full_PC, 32'h0);

        // Coalesce into a head held by a fetch conflict
        req(1'b1, 32'h2C);
        r0(32'h20, 9'd0, 8'h01);
        tick(); rclr(); r0(32'h20, 9'd0, 8'h02); settle();
        chk("coal_stalled", 32'(update0_valid), 32'd0);
        tick(); rclr(); settle();
        chk("coal_occ", 32'(occupancy), 32'd1);
        chk("coal_lh", 32'(update0_LH), 32'h02);
        req(1'b0, 32'h0); settle();
        chk("coal_drain", 32'(update0_valid), 32'd1);
        tick(); settle();
        chk("coal_empty", 32'(occupancy), 32'd0);

        // Same-cycle dual, equal keys: only the younger survives
        r0(32'h40, 9'd3, 8'h11); r1(32'h40, 9'd3, 8'h22);
        tick(); rclr(); settle();
        chk("dual_eq_occ", 32'(occupancy), 32'd1);
        chk("dual_eq_lh", 32'(update0_LH), 32'h22);
        chk("dual_eq_asid", 32'(update0_ASID), 32'd3);
        tick(); settle();
        // Different keys: FIFO order r0 then r1
        r0(32'h60, 9'd1, 8'h33); r1(32'h70, 9'd1, 8'h44);
        tick(); rclr(); settle();
        chk("dual_ne_occ", 32'(occupancy), 32'd2);
        chk("dual_ne_first", update0_start_full_PC, 32'h60);
        tick(); settle();
        chk("dual_ne_second", update0_start_full_PC, 32'h70);
        chk("dual_ne_second_lh", 32'(update0_LH), 32'h44);
        tick(); settle();
        chk("dual_ne_empty", 32'(occupancy), 32'd0);

        // Conflict stall with bounded starvation
        req(1'b1, 32'h3E);
        r0(32'h30, 9'd0, 8'h55);
        tick(); rclr(); settle();
        chk("stall_c1", 32'(update0_valid), 32'd0);
        tick(); settle();
        chk("stall_c2", 32'(update0_valid), 32'd0);
        tick(); settle();
        chk("stall_c3", 32'(update0_valid), 32'd0);
        tick(); settle();
        chk("stall_forced", 32'(update0_valid), 32'd1);
        tick(); settle();
        chk("stall_empty", 32'(occupancy), 32'd0);
        req(1'b1, 32'h50);
        r0(32'h30, 9'd0, 8'h66);
        tick(); rclr(); settle();
        chk("other_set_drain", 32'(update0_valid), 32'd1);
        chk("other_set_lh", 32'(update0_LH), 32'h66);
        tick(); settle();
        req(1'b0, 32'h0);

        // Overflow with drain blocked
        req(1'b1, 32'h80);
        r0(32'h80, 9'd0, 8'h81); r1(32'h90, 9'd0, 8'h91);
        tick(); rclr(); r0(32'hA0, 9'd0, 8'hA1); r1(32'hB0, 9'd0, 8'hB1); settle();
        chk("ovf_ready2", 32'(resolve_ready), 32'd1);
        chk("ovf_occ2", 32'(occupancy), 32'd2);
        tick(); rclr(); r0(32'hC0, 9'd0, 8'hC1); settle();
        chk("ovf_occ4", 32'(occupancy), 32'd4);
        chk("ovf_ready0", 32'(resolve_ready), 32'd0);
        chk("ovf_not_yet", 32'(overflow_error), 32'd0);
        tick(); rclr(); settle();
        chk("ovf_flag", 32'(overflow_error), 32'd1);
        chk("ovf_occ_hold", 32'(occupancy), 32'd4);
        tick(); settle();
        chk("ovf_forced", 32'(update0_valid), 32'd1);
        chk("ovf_head", update0_start_full_PC, 32'h80);
        // Slot freed by this cycle's drain accepts a new entry
        r0(32'hC0, 9'd0, 8'hC2); req(1'b0, 32'h0);
        tick(); rclr(); settle();
        chk("ovf_refill_occ", 32'(occupancy), 32'd4);
        chk("ovf_order_b", update0_start_full_PC, 32'h90);
        tick(); settle();
        chk("ovf_order_c", update0_start_full_PC, 32'hA0);
        tick(); settle();
        chk("ovf_order_d", update0_start_full_PC, 32'hB0);
        tick(); settle();
        chk("ovf_order_e", update0_start_full_PC, 32'hC0);
        chk("ovf_order_e_lh", 32'(update0_LH), 32'hC2);
        tick(); settle();
        chk("ovf_drained", 32'(occupancy), 32'd0);
        chk("ovf_sticky", 32'(overflow_error), 32'd1);

        // Wrap: eight push/pop cycles keep FIFO order
        for (int i = 0; i < 8; i++) begin
            r0(32'h100 + 32'(i) * 32'h10, 9'd2, 8'(8'h90 + i));
            settle();
            if (i > 0) begin
                chk("wrap_head", update0_start_full_PC, 32'h100 + 32'(i - 1) * 32'h10);
            end
            tick();
        end
        rclr(); settle();
        chk("wrap_last", update0_start_full_PC, 32'h170);
        chk("wrap_last_lh", 32'(update0_LH), 32'h97);
        tick(); settle();
        chk("wrap_empty", 32'(occupancy), 32'd0);

        // Asynchronous reset mid-stream with three entries queued
        req(1'b1, 32'h200);
        r0(32'h200, 9'd0, 8'h01); r1(32'h210, 9'd0, 8'h02);
        tick(); rclr(); r0(32'h220, 9'd0, 8'h03);
        tick(); rclr(); settle();
        chk("rst_pre_occ", 32'(occupancy), 32'd3);
        RST = 1'b1; settle();
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_valid", 32'(update0_valid), 32'd0);
        chk("rst_ready", 32'(resolve_ready), 32'd1);
        chk("rst_ovf", 32'(overflow_error), 32'd0);
        tick();
        RST = 1'b0; req(1'b0, 32'h0);
        r0(32'h10, 9'd0, 8'h77);
        tick(); rclr(); settle();
        chk("post_rst_valid", 32'(update0_valid), 32'd1);
        chk("post_rst_lh", 32'(update0_LH), 32'h77);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
